// File: rtl/p_addsub_pkg.sv
// Shared definitions for the packed add/sub datapath and its arbiter:
// one-hot pack-width encodings, the pack-width legality check, the
// lane-boundary helper used by the carry chain, and the hold-register record.
package p_addsub_pkg;

  localparam logic [4:0] PW_32 = 5'b00001;
  localparam logic [4:0] PW_16 = 5'b00010;
  localparam logic [4:0] PW_8  = 5'b00100;
  localparam logic [4:0] PW_4  = 5'b01000;
  localparam logic [4:0] PW_2  = 5'b10000;

  // Registered result stage: one entry, tagged with the requester that issued it.
  typedef struct packed {
    logic        full;
    logic        owner;
    logic [31:0] result;
    logic        err;
  } hold_t;

  // A pack width is legal only when exactly one lane-size bit is set.
  function automatic logic pw_onehot(input logic [4:0] pw);
    return (pw != 5'b00000) && ((pw & (pw - 5'd1)) == 5'b00000);
  endfunction

  // True when bit_idx is the least significant bit of a lane for this width,
  // i.e. where the carry chain must be restarted.
  function automatic logic lane_start(input logic [4:0] bit_idx, input logic [4:0] pw);
    return (bit_idx == 5'd0)
         | (pw[1] & (bit_idx[3:0] == 4'd0))
         | (pw[2] & (bit_idx[2:0] == 3'd0))
         | (pw[3] & (bit_idx[1:0] == 2'd0))
         | (pw[4] & (bit_idx[0]   == 1'b0));
  endfunction

endpackage

// File: rtl/p_addsub.sv
// Packed SIMD adder/subtractor: one 32-bit ripple chain that is cut at every
// lane boundary selected by the one-hot pack width. Subtraction is done as
// lhs + ~rhs + 1 with the +1 injected at the bottom of each lane.
module p_addsub
  import p_addsub_pkg::*;
(
  input  logic [31:0] i_lhs,
  input  logic [31:0] i_rhs,
  input  logic [4:0]  i_pw,
  input  logic        i_sub,
  output logic [31:0] o_result
);

  logic [31:0] w_bop;
  logic [31:0] w_sum;
  logic        w_carry;

  // Lane-segmented ripple carry; the carry restarts at each lane base.
  always_comb begin
    w_bop   = i_sub ? ~i_rhs : i_rhs;
    w_sum   = '0;
    w_carry = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (lane_start(5'(i), i_pw)) begin
        w_carry = i_sub;
      end
      w_sum[i] = i_lhs[i] ^ w_bop[i] ^ w_carry;
      w_carry  = (i_lhs[i] & w_bop[i]) | (w_carry & (i_lhs[i] ^ w_bop[i]));
    end
  end

  assign o_result = w_sum;

endmodule

// File: rtl/p_addsub_arb.sv
// Two-requester round-robin front end for the shared packed add/sub datapath.
// A single registered hold stage returns each result on the response channel
// of the requester that issued it; a new operation can be accepted in the same
// cycle the held result drains, so throughput is one op per cycle.
module p_addsub_arb
  import p_addsub_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_lhs,
  input  logic [32*NREQ-1:0]   req_rhs,
  input  logic [5*NREQ-1:0]    req_pw,
  input  logic [NREQ-1:0]      req_sub,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err
);

  hold_t       r_hold;
  logic        r_ptr;

  logic        w_drain;
  logic        w_can_accept;
  logic        w_grant_any;
  logic        w_grant_idx;
  logic [1:0]  w_grant;
  logic        w_accept;
  logic [31:0] w_lhs;
  logic [31:0] w_rhs;
  logic [4:0]  w_pw;
  logic        w_sub;
  logic        w_pw_legal;
  logic [31:0] w_dp_result;

  // The held result leaves when its own requester takes it; the other
  // requester's rsp_ready is irrelevant because there is no per-requester buffer.
  assign w_drain      = r_hold.full & rsp_ready[r_hold.owner];
  assign w_can_accept = g_resetn & (~r_hold.full | w_drain);

  // Round-robin grant: the pointer only breaks ties when both requesters are valid.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = 1'b0;
    case (req_valid)
      2'b01: begin
        w_grant_any = 1'b1;
        w_grant_idx = 1'b0;
      end
      2'b10: begin
        w_grant_any = 1'b1;
        w_grant_idx = 1'b1;
      end
      2'b11: begin
        w_grant_any = 1'b1;
        w_grant_idx = r_ptr;
      end
      default: begin
        w_grant_any = 1'b0;
        w_grant_idx = 1'b0;
      end
    endcase
  end

  assign w_grant   = {w_grant_any & w_grant_idx, w_grant_any & ~w_grant_idx};
  assign req_ready = w_grant & {2{w_can_accept}};
  assign w_accept  = w_grant_any & w_can_accept;

  // Operand mux feeding the shared datapath from the granted requester.
  assign w_lhs      = w_grant_idx ? req_lhs[63:32] : req_lhs[31:0];
  assign w_rhs      = w_grant_idx ? req_rhs[63:32] : req_rhs[31:0];
  assign w_pw       = w_grant_idx ? req_pw[9:5]    : req_pw[4:0];
  assign w_sub      = w_grant_idx ? req_sub[1]     : req_sub[0];
  assign w_pw_legal = pw_onehot(w_pw);

  p_addsub u_p_addsub (
    .i_lhs    (w_lhs),
    .i_rhs    (w_rhs),
    .i_pw     (w_pw),
    .i_sub    (w_sub),
    .o_result (w_dp_result)
  );

  // Hold register and priority pointer; a drain without a new accept only
  // clears full and leaves the last result/err in place.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_hold <= '0;
      r_ptr  <= 1'b0;
    end else if (w_accept) begin
      r_hold.full   <= 1'b1;
      r_hold.owner  <= w_grant_idx;
      r_hold.result <= w_pw_legal ? w_dp_result : 32'h0000_0000;
      r_hold.err    <= ~w_pw_legal;
      r_ptr         <= ~w_grant_idx;
    end else if (w_drain) begin
      r_hold.full <= 1'b0;
    end
  end

  assign rsp_valid  = {r_hold.full & r_hold.owner, r_hold.full & ~r_hold.owner};
  assign rsp_result = r_hold.result;
  assign rsp_err    = r_hold.err;

endmodule

// File: tb/tb_p_addsub_arb.sv
// Directed testbench for p_addsub_arb: single ops on each lane width,
// round-robin contention, back-pressure, illegal pack widths and an
// asynchronous reset while a result is held.
module tb_p_addsub_arb;

  logic        g_clk;
  logic        g_resetn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_lhs;
  logic [63:0] req_rhs;
  logic [9:0]  req_pw;
  logic [1:0]  req_sub;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;

  int checks;
  int failures;

  p_addsub_arb #(.NREQ(2)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .req_pw     (req_pw),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  // Free-running 10 ns clock.
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Request-stability watcher: a request left waiting at one cycle must still
  // be presented, unchanged, in the next.
  logic [1:0]  prevPending;
  logic [63:0] prevLhs;
  logic [63:0] prevRhs;
  logic [9:0]  prevPw;
  logic [1:0]  prevSub;
  logic        prevArmed;
  initial prevArmed = 1'b0;
  always @(negedge g_clk) begin
    if (prevArmed && g_resetn) begin
      for (int r = 0; r < 2; r++) begin
        if (prevPending[r] && (!req_valid[r] ||
            req_lhs[r*32 +: 32] !== prevLhs[r*32 +: 32] ||
            req_rhs[r*32 +: 32] !== prevRhs[r*32 +: 32] ||
            req_pw[r*5 +: 5] !== prevPw[r*5 +: 5] ||
            req_sub[r] !== prevSub[r])) begin
          failures++;
          $display("[TB] FAIL req_stable%0d: valid=%b while pending request was not yet accepted", r, req_valid);
        end
      end
    end
    prevPending = req_valid & ~req_ready;
    prevLhs     = req_lhs;
    prevRhs     = req_rhs;
    prevPw      = req_pw;
    prevSub     = req_sub;
    prevArmed   = g_resetn;
  end

  // Load one requester's operands and raise its valid bit.
  task automatic applyStimulus(input int r, input logic [31:0] lhs, input logic [31:0] rhs,
                               input logic [4:0] pw, input logic sub);
    if (r == 0) begin
      req_lhs[31:0] = lhs;
      req_rhs[31:0] = rhs;
      req_pw[4:0]   = pw;
      req_sub[0]    = sub;
      req_valid[0]  = 1'b1;
    end else begin
      req_lhs[63:32] = lhs;
      req_rhs[63:32] = rhs;
      req_pw[9:5]    = pw;
      req_sub[1]     = sub;
      req_valid[1]   = 1'b1;
    end
  endtask

  task automatic test_reset();
    g_resetn  = 1'b0;
    req_valid = 2'b11;
    req_lhs   = '0;
    req_rhs   = '0;
    req_pw    = {5'b00001, 5'b00001};
    req_sub   = 2'b00;
    rsp_ready = 2'b11;
    #3;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL reset_req_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin failures++; $display("[TB] FAIL reset_rsp_result: got %h want 00000000", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_err: got %b want 0", rsp_err); end
    req_valid = 2'b00;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0]  expReady;
    logic [31:0] expResult;
    @(posedge g_clk); #1;
    applyStimulus(0, 32'd1, 32'd2, 5'b00001, 1'b0);
    applyStimulus(1, 32'd10, 32'd3, 5'b00001, 1'b1);
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      expReady  = (k % 2 == 0) ? 2'b01 : 2'b10;
      expResult = (k % 2 == 0) ? 32'd3 : 32'd7;
      #1;
      checks++; if (req_ready !== expReady) begin failures++; $display("[TB] FAIL contend_grant%0d: got %b want %b", k, req_ready, expReady); end
      @(posedge g_clk); #1;
      checks++; if (rsp_valid !== expReady) begin failures++; $display("[TB] FAIL contend_rsp_valid%0d: got %b want %b", k, rsp_valid, expReady); end
      checks++; if (rsp_result !== expResult) begin failures++; $display("[TB] FAIL contend_result%0d: got %h want %h", k, rsp_result, expResult); end
    end
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL contend_ptr_end: got %b want 01", req_ready); end
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("[TB] FAIL contend_last_rsp: got %b want 01", rsp_valid); end
  endtask

  task automatic test_add16();
    @(posedge g_clk); #1;
    applyStimulus(0, 32'h00FF00FF, 32'h00010001, 5'b00010, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL add16_ready: got %b want 01", req_ready); end
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("[TB] FAIL add16_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_result !== 32'h01000100) begin failures++; $display("[TB] FAIL add16_result: got %h want 01000100", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL add16_err: got %b want 0", rsp_err); end
  endtask

  task automatic test_sub8();
    @(posedge g_clk); #1;
    applyStimulus(1, 32'h10203040, 32'h01010101, 5'b00100, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("[TB] FAIL sub8_ready: got %b want 10", req_ready); end
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b10) begin failures++; $display("[TB] FAIL sub8_rsp_valid: got %b want 10", rsp_valid); end
    checks++; if (rsp_result !== 32'h0F1F2F3F) begin failures++; $display("[TB] FAIL sub8_result: got %h want 0F1F2F3F", rsp_result); end
    @(posedge g_clk); #1;
    applyStimulus(0, 32'h00000000, 32'h00000001, 5'b00100, 1'b1);
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("[TB] FAIL wrap8_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_result !== 32'h000000FF) begin failures++; $display("[TB] FAIL wrap8_result: got %h want 000000FF", rsp_result); end
  endtask

  task automatic test_back_to_back();
    @(posedge g_clk); #1;
    rsp_ready = 2'b10;
    applyStimulus(0, 32'h12345678, 32'h11111111, 5'b00001, 1'b0);
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    applyStimulus(1, 32'h0000FFFF, 32'h00000001, 5'b00010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge g_clk); #1;
      end
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL bp_ready%0d: got %b want 00", k, req_ready); end
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("[TB] FAIL bp_rsp_valid%0d: got %b want 01", k, rsp_valid); end
      checks++; if (rsp_result !== 32'h23456789) begin failures++; $display("[TB] FAIL bp_result%0d: got %h want 23456789", k, rsp_result); end
    end
    rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("[TB] FAIL bp_release_ready: got %b want 10", req_ready); end
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b10) begin failures++; $display("[TB] FAIL bp_next_rsp_valid: got %b want 10", rsp_valid); end
    checks++; if (rsp_result !== 32'h00000000) begin failures++; $display("[TB] FAIL bp_next_result: got %h want 00000000", rsp_result); end
  endtask

  task automatic test_illegal_pw();
    @(posedge g_clk); #1;
    applyStimulus(0, 32'hFFFFFFFF, 32'h00000001, 5'b00011, 1'b0);
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_result !== 32'h0) begin failures++; $display("[TB] FAIL ill11_result: got %h want 00000000", rsp_result); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("[TB] FAIL ill11_err: got %b want 1", rsp_err); end
    @(posedge g_clk); #1;
    applyStimulus(0, 32'hFFFFFFFF, 32'h00000001, 5'b00000, 1'b0);
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("[TB] FAIL ill00_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin failures++; $display("[TB] FAIL ill00_result: got %h want 00000000", rsp_result); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("[TB] FAIL ill00_err: got %b want 1", rsp_err); end
    @(posedge g_clk); #1;
    applyStimulus(0, 32'h00000004, 32'h00000003, 5'b00001, 1'b0);
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL legal_after_err: got %b want 0", rsp_err); end
    checks++; if (rsp_result !== 32'h7) begin failures++; $display("[TB] FAIL legal_after_result: got %h want 00000007", rsp_result); end
  endtask

  task automatic test_reset_midop();
    @(posedge g_clk); #1;
    rsp_ready = 2'b00;
    applyStimulus(0, 32'd5, 32'd3, 5'b00001, 1'b1);
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_result !== 32'd2) begin failures++; $display("[TB] FAIL midop_held: got %h want 00000002", rsp_result); end
    #2;
    g_resetn = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("[TB] FAIL midop_rsp_valid: got %b want 00", rsp_valid); end
    @(posedge g_clk); #1;
    g_resetn  = 1'b1;
    rsp_ready = 2'b11;
    applyStimulus(0, 32'd8, 32'd1, 5'b00001, 1'b0);
    applyStimulus(1, 32'd8, 32'd1, 5'b00001, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL midop_first_grant: got %b want 01", req_ready); end
    @(posedge g_clk); #1;
    req_valid = 2'b10;
    checks++; if (rsp_result !== 32'd9) begin failures++; $display("[TB] FAIL midop_r0_result: got %h want 00000009", rsp_result); end
    @(posedge g_clk); #1;
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b10) begin failures++; $display("[TB] FAIL midop_r1_rsp_valid: got %b want 10", rsp_valid); end
    checks++; if (rsp_result !== 32'd7) begin failures++; $display("[TB] FAIL midop_r1_result: got %h want 00000007", rsp_result); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_contention();
    test_add16();
    test_sub8();
    test_back_to_back();
    test_illegal_pw();
    test_reset_midop();
    repeat (2) @(posedge g_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
